mainfsm: RTL and testbench

Multicycle main controller FSM for the ARM datapath. It sequences every instruction through fetch, decode, execute, memory and writeback cycles, and drives the datapath mux selects and write strobes. The unconditioned strobes `RegW`, `MemW`, `Branch` and `FlagW`-qualifying `ALUOp` go to the conditional-execution logic, which gates them with the condition result. `NextPC` and `IRWrite` go directly to the PC and instruction registers.

---
 rtl/arm_pkg.sv | 40 ++++
 rtl/mainfsm.sv | 135 +++++++++++++
 tb/tb_mainfsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the multicycle ARM controller: state encoding,
// instruction-class codes and datapath mux select codes.
// Pure declarations; no logic.
package arm_pkg;

  // Controller states; 11 states in a 4-bit encoding, codes 11..15 unused
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } statetype_t;

  // Instruction class, taken from instruction bits [27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALU A operand select
  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback.
// Latency: LDR 5, STR 4, data-processing 4, branch 3, undefined 3 cycles.
// Moore outputs only; no backpressure. Async active-high reset lands in FETCH.
module mainfsm
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp
);

  statetype_t state_q;
  statetype_t state_d;

  // Only the I bit and the L bit steer the sequence; the rest of Funct
  // belongs to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register; reset forces FETCH so no pending write strobe survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; Op/Funct are only looked at in DECODE and MEMADR
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWR:    state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      // UNKNOWN and any illegal encoding drop back to FETCH
      default:  state_d = FETCH;
    endcase
  end

  // Output decode; UNKNOWN and illegal encodings keep every output at 0
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    case (state_q)
      FETCH: begin
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
      end
      DECODE: begin
        // Precompute PC+8 so a branch target can use it
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b0;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemW      = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_REG;
        ALUOp   = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegW      = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        Branch    = 1'b1;
        ALUOp     = 1'b0;
      end
      default: begin
        // all outputs stay 0
      end
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// Testbench for mainfsm: directed instruction sequences, a mid-MEMWR reset,
// then random instructions, each checked cycle by cycle against a table model.
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

  int vectors    = 0;
  int miscompares = 0;

  mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp)
  );

  always #5 clk = ~clk;

  // Output bundle: {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
  function automatic logic [12:0] mk(input logic irw, input logic adr, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] res, input logic npc,
                                     input logic rw, input logic mw, input logic br, input logic aop);
    return {irw, adr, a, b, res, npc, rw, mw, br, aop};
  endfunction

  // Expected output bundle for each step an instruction can go through
  logic [12:0] V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_MEMWR;
  logic [12:0] V_EXECR, V_EXECI, V_ALUWB, V_BRANCH, V_UNK;

  function automatic logic [12:0] observed();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Runs one instruction from a FETCH negedge to the next FETCH negedge,
  // comparing each cycle and the per-instruction strobe counts.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input string tag);
    logic [12:0] exp[$];
    int n_rw, n_mw, n_br, n_npc, n_irw;
    int e_rw, e_mw, e_br;
    logic [12:0] o;
    Op    = op;
    Funct = funct;
    exp.push_back(V_FETCH);
    exp.push_back(V_DECODE);
    e_rw = 0; e_mw = 0; e_br = 0;
    case (op)
      2'b01: begin
        exp.push_back(V_MEMADR);
        if (funct[0]) begin exp.push_back(V_MEMRD); exp.push_back(V_MEMWB); e_rw = 1; end
        else          begin exp.push_back(V_MEMWR); e_mw = 1; end
      end
      2'b00: begin
        exp.push_back(funct[5] ? V_EXECI : V_EXECR);
        exp.push_back(V_ALUWB);
        e_rw = 1;
      end
      2'b10: begin exp.push_back(V_BRANCH); e_br = 1; end
      default: exp.push_back(V_UNK);
    endcase
    n_rw = 0; n_mw = 0; n_br = 0; n_npc = 0; n_irw = 0;
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      o = observed();
      check($sformatf("%s_c%0d", tag, i + 1), o, exp[i]);
      n_irw += int'(IRWrite); n_npc += int'(NextPC);
      n_rw  += int'(RegW);    n_mw  += int'(MemW); n_br += int'(Branch);
    end
    check({tag, "_strobes"}, {n_irw[2:0], n_npc[2:0], n_rw[2:0], n_mw[2:0], n_br[0]},
          {3'd1, 3'd1, e_rw[2:0], e_mw[2:0], e_br[0]});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_back_to_fetch"}, observed(), V_FETCH);
  endtask

  initial begin
    logic [1:0] rop;
    logic [5:0] rfn;
    V_FETCH  = mk(1, 0, 2'b01, 2'b10, 2'b10, 1, 0, 0, 0, 0);
    V_DECODE = mk(0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 0);
    V_MEMADR = mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0);
    V_MEMRD  = mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    V_MEMWB  = mk(0, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0, 0, 0);
    V_MEMWR  = mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0);
    V_EXECR  = mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1);
    V_EXECI  = mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 1);
    V_ALUWB  = mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 0);
    V_BRANCH = mk(0, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0, 1, 0);
    V_UNK    = 13'd0;

    // Reset state
    reset = 1'b1;
    Op    = 2'b11;
    Funct = 6'd0;
    #1;
    check("reset_outputs", observed(), V_FETCH);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held", observed(), V_FETCH);
    reset = 1'b0;

    // Directed instructions
    run_instr(2'b01, 6'b011001, "ldr");
    run_instr(2'b01, 6'b011000, "str");
    run_instr(2'b00, 6'b001000, "add_reg");
    run_instr(2'b00, 6'b101000, "add_imm");
    run_instr(2'b10, 6'b000000, "branch");
    run_instr(2'b11, 6'b111111, "undef");

    // Reset asserted while a store is in MEMWR
    Op    = 2'b01;
    Funct = 6'b011000;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_reset_memwr", observed(), V_MEMWR);
    #2 reset = 1'b1;
    #1;
    check("reset_mid_memw", {12'd0, MemW}, 13'd0);
    check("reset_mid_outputs", observed(), V_FETCH);
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_held", observed(), V_FETCH);
    reset = 1'b0;
    run_instr(2'b10, 6'b000001, "post_reset_branch");

    // Random instructions
    for (int k = 0; k < 80; k++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = 6'($urandom);
      run_instr(rop, rfn, $sformatf("rand%0d_op%0d", k, rop));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
